// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two memory-2 RSC encoders (1+D+D^2 feedback, 1+D^2 feedforward)
// run bit-serially over a 5-bit block with a fixed interleaver, each terminated by 2 tail steps.
module turbo_encoder (
  input  logic        clk_p_i,
  input  logic        reset_n_i,
  input  logic [4:0]  info_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [20:0] data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam int unsigned INPUT_SIZE  = 5;
  localparam int unsigned EXTEND_SIZE = INPUT_SIZE + 2;
  localparam int unsigned BLOCK_SIZE  = 3 * EXTEND_SIZE;
  localparam int unsigned K_W         = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_TAIL = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [K_W-1:0]          r_k;
  logic [INPUT_SIZE-1:0]   r_info;
  logic                    r_s1a, r_s2a, r_s1b, r_s2b;
  logic [EXTEND_SIZE-1:0]  r_sys, r_par1, r_par2;
  logic [BLOCK_SIZE-1:0]   r_data;
  logic                    r_in_ready;
  logic                    r_out_valid;

  logic                    w_accept, w_step;
  logic                    w_u1, w_u2, w_a1, w_a2, w_p1, w_p2;
  logic [EXTEND_SIZE-1:0]  w_sys_full, w_par1_full, w_par2_full;

  // Next state, encoder inputs (info order for RSC1, interleaved order for RSC2) and step outputs
  always_comb begin
    w_state_nx  = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_u1        = 1'b0;
    w_u2        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid_i) begin
          w_accept   = 1'b1;
          w_state_nx = S_ENC;
        end
      end
      S_ENC: begin
        w_step = 1'b1;
        case (r_k)
          3'd0:    begin w_u1 = r_info[0]; w_u2 = r_info[0]; end
          3'd1:    begin w_u1 = r_info[1]; w_u2 = r_info[3]; end
          3'd2:    begin w_u1 = r_info[2]; w_u2 = r_info[1]; end
          3'd3:    begin w_u1 = r_info[3]; w_u2 = r_info[4]; end
          3'd4:    begin w_u1 = r_info[4]; w_u2 = r_info[2]; end
          default: begin w_u1 = 1'b0;      w_u2 = 1'b0;      end
        endcase
        if (r_k == K_W'(INPUT_SIZE - 1)) w_state_nx = S_TAIL;
      end
      S_TAIL: begin
        w_step = 1'b1;
        // Tail input cancels the feedback so each trellis returns to zero
        w_u1   = r_s1a ^ r_s2a;
        w_u2   = r_s1b ^ r_s2b;
        if (r_k == K_W'(EXTEND_SIZE - 1)) w_state_nx = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase

    w_a1 = w_u1 ^ r_s1a ^ r_s2a;
    w_a2 = w_u2 ^ r_s1b ^ r_s2b;
    w_p1 = w_a1 ^ r_s2a;
    w_p2 = w_a2 ^ r_s2b;

    w_sys_full       = r_sys;
    w_par1_full      = r_par1;
    w_par2_full      = r_par2;
    w_sys_full[r_k]  = w_u1;
    w_par1_full[r_k] = w_p1;
    w_par2_full[r_k] = w_p2;
  end

  // State, trellis registers and the output word, captured only when the last tail step completes
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_info      <= '0;
      r_s1a       <= 1'b0;
      r_s2a       <= 1'b0;
      r_s1b       <= 1'b0;
      r_s2b       <= 1'b0;
      r_sys       <= '0;
      r_par1      <= '0;
      r_par2      <= '0;
      r_data      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == S_IDLE);
      r_out_valid <= (w_state_nx == S_OUT);
      if (w_accept) begin
        r_info <= info_i;
        r_k    <= '0;
        r_s1a  <= 1'b0;
        r_s2a  <= 1'b0;
        r_s1b  <= 1'b0;
        r_s2b  <= 1'b0;
        r_sys  <= '0;
        r_par1 <= '0;
        r_par2 <= '0;
      end else if (w_step) begin
        r_k    <= r_k + K_W'(1);
        r_s1a  <= w_a1;
        r_s2a  <= r_s1a;
        r_s1b  <= w_a2;
        r_s2b  <= r_s1b;
        r_sys  <= w_sys_full;
        r_par1 <= w_par1_full;
        r_par2 <= w_par2_full;
        if (w_state_nx == S_OUT) r_data <= {w_sys_full, w_par1_full, w_par2_full};
      end
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign data_o      = r_data;

endmodule

// File: tb/tb_turbo_encoder.sv
// Directed and random-vector bench for turbo_encoder: latency, code words, stall, reset, throughput.
module tb_turbo_encoder;

  logic        clk_p_i;
  logic        reset_n_i;
  logic [4:0]  info_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [20:0] data_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  turbo_encoder dut (
    .clk_p_i     (clk_p_i),
    .reset_n_i   (reset_n_i),
    .info_i      (info_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_o      (data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  initial clk_p_i = 1'b0;
  always #5 clk_p_i = ~clk_p_i;
  always @(posedge clk_p_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: two RSC encoders, interleaver index (3k) mod 5, 2 tail steps each
  function automatic logic [20:0] model(input logic [4:0] info);
    logic [6:0] sys, p1, p2;
    logic s1a, s2a, s1b, s2b, u1, u2, a1, a2;
    s1a = 0; s2a = 0; s1b = 0; s2b = 0;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        u1 = info[k];
        u2 = info[(3 * k) % 5];
      end else begin
        u1 = s1a ^ s2a;
        u2 = s1b ^ s2b;
      end
      a1 = u1 ^ s1a ^ s2a;
      a2 = u2 ^ s1b ^ s2b;
      sys[k] = u1;
      p1[k]  = a1 ^ s2a;
      p2[k]  = a2 ^ s2b;
      s2a = s1a; s1a = a1;
      s2b = s1b; s1b = a2;
    end
    return {sys, p1, p2};
  endfunction

  task automatic tick();
    @(posedge clk_p_i);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_o && n < 30) begin tick(); n++; end
    check("in_ready_wait", 32'(in_ready_o), 32'd1);
  endtask

  // Accept one block, check 8-edge latency and code word; returns after the valid is first seen
  task automatic send_block(input string tag, input logic [4:0] info, input logic [20:0] exp);
    int n = 0;
    wait_ready();
    info_i = info; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    while (!out_valid_o && n < 20) begin tick(); n++; end
    check({tag, "_lat"}, 32'(n + 1), 32'd8);
    check({tag, "_data"}, 32'(data_o), 32'(exp));
  endtask

  logic [20:0] held;
  logic [4:0]  rnd;
  int          acc_cyc, prev_cyc, n;

  initial begin
    reset_n_i = 1'b0; info_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    reset_n_i = 1'b1;
    tick();

    // All-zero block, valid for exactly one cycle
    send_block("zero", 5'b00000, 21'h000000);
    check("zero_valid", 32'(out_valid_o), 32'd1);
    tick();
    check("zero_valid_1cyc", 32'(out_valid_o), 32'd0);
    check("zero_ready_back", 32'(in_ready_o), 32'd1);

    send_block("one", 5'b00001, 21'h107BF7);
    tick();
    send_block("intlv", 5'b01000, 21'h123C4E);
    tick();

    // Back-pressure with an ignored input pulse mid-stall
    out_ready_i = 1'b0;
    send_block("bp", 5'b10110, model(5'b10110));
    held = data_o;
    for (int i = 0; i < 20; i++) begin
      if (i == 7) begin info_i = 5'b11111; in_valid_i = 1'b1; end
      if (i == 8) in_valid_i = 1'b0;
      tick();
      check("bp_data_hold", 32'(data_o), 32'(held));
      check("bp_valid_hold", 32'(out_valid_o), 32'd1);
      check("bp_in_ready", 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid_o), 32'd0);
    check("bp_release_ready", 32'(in_ready_o), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (out_valid_o) n++; end
    check("bp_pulse_ignored", 32'(n), 32'd0);

    // Reset during step k = 3
    wait_ready();
    info_i = 5'b11011; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick(); tick(); tick();
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_data", 32'(data_o), 32'd0);
    tick();
    reset_n_i = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (out_valid_o) n++; end
    check("mid_rst_no_output", 32'(n), 32'd0);
    send_block("after_rst", 5'b00001, 21'h107BF7);
    tick();

    // Back-to-back random blocks, in_valid held high
    in_valid_i = 1'b1;
    prev_cyc = 0;
    for (int b = 0; b < 50; b++) begin
      wait_ready();
      rnd = 5'($urandom_range(0, 31));
      info_i = rnd;
      tick();
      acc_cyc = cyc;
      if (b > 0) check("b2b_spacing", 32'(acc_cyc - prev_cyc), 32'd9);
      prev_cyc = acc_cyc;
      n = 0;
      while (!out_valid_o && n < 20) begin tick(); n++; end
      check("b2b_data", 32'(data_o), 32'(model(rnd)));
      tick();
    end
    in_valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/turbo_encoder.md
# turbo_encoder

Rate-1/3 parallel-concatenated (turbo) encoder that produces the 21-bit code blocks consumed by the turbo decoder. It takes 5 information bits and runs two identical memory-2 recursive systematic convolutional (RSC) encoders bit-serially, one trellis step per cycle. The second encoder works on a fixed 5-bit interleaved order. It terminates both trellises with 2 tail steps and presents {systematic, parity1, parity2} as one registered word under a valid/ready handshake.

## Interface
- input_size, 5, information bits per block (fixed at 5; interleaver below is defined for 5)
- extend_size, 7, trellis steps per block (input_size + 2 tail)
- block_size, 21, output word width (3 * extend_size)
- clk_p_i  input  1  clock, rising edge
- reset_n_i  input  1  asynchronous, active-low reset
- info_i  input  5  information bits; bit k is trellis step k
- in_valid_i  input  1  info_i valid
- in_ready_o  output  1  encoder can accept a block
- data_o  output  21  code block: data_o[14+k] = sys[k], data_o[7+k] = par1[k], data_o[k] = par2[k], k = 0..6
- out_valid_o  output  1  data_o holds a complete block
- out_ready_i  input  1  downstream accepts data_o

## Operation
- FSM states: IDLE, ENC, TAIL, OUT.
- IDLE
  - in_ready_o = 1.
  - On in_valid_i && in_ready_o: latch info_i, clear both RSC states to (s1,s2) = (0,0), clear step counter k = 0, go to ENC.
- RSC step, for both encoders, given input u:
  - a = u ^ s1 ^ s2 (feedback 1+D+D^2)
  - p = a ^ s2 (feedforward 1+D^2)
  - next state (s1,s2) = (a, s1)
- ENC, k = 0..4
  - Encoder 1 input: u1 = info[k].
  - Encoder 2 input: u2 = info[(3k) mod 5], i.e. order info[0], info[3], info[1], info[4], info[2].
  - Store sys[k] = u1, par1[k] = p1, par2[k] = p2.
  - k increments every cycle; after k = 4 go to TAIL.
- TAIL, k = 5, 6
  - Each encoder independently uses u = s1 ^ s2, which forces a = 0. Then p = s2 and next state = (0, s1).
  - Store sys[k] = encoder-1 tail input, par1[k] and par2[k] = the respective p.
  - Encoder-2 tail systematic bits are not transmitted.
  - After k = 6 both states are (0,0). Go to OUT.
- OUT
  - out_valid_o = 1; data_o is stable and driven from a register.
  - On out_ready_i: go to IDLE.
- in_ready_o = 0 in ENC, TAIL and OUT.
- in_valid_i is ignored in ENC, TAIL and OUT; blocks are never queued.
- data_o keeps its last value outside OUT; only out_valid_o qualifies it.

## Timing
- Reset values: in_ready_o = 1, out_valid_o = 0, data_o = 0, state IDLE, RSC states 0, k = 0.
- Reset asserted mid-block: the block is discarded immediately and all reset values apply. No partial output is ever produced.
- Latency:
  - Acceptance edge E.
  - ENC occupies edges E+1..E+5 and TAIL occupies E+6..E+7.
  - out_valid_o goes high after edge E+7 and is first sampled at edge E+8.
- Back-pressure: out_valid_o and data_o are held unchanged until the edge where out_ready_i = 1.
- After that edge, in_ready_o = 1 and out_valid_o = 0.
- Minimum spacing: one block every 9 cycles (accept, 7 steps, output handshake).
- No combinational path from any input to any output; every output comes straight from a register or is decoded from state.

## Test plan
- Reset then all-zero info_i = 5'b00000 with out_ready_i held 1 -> data_o = 21'h000000, with out_valid_o high for exactly 1 cycle, 8 edges after acceptance.
- info_i = 5'b00001, out_ready_i = 1 -> sys = 7'b1000001, par1 = 7'b1110111, par2 = 7'b1110111, so data_o = 21'h107BF7.
- Interleaver check, info_i = 5'b01000 -> sys = 7'b1001000, par1 = 7'b1111000, par2 = 7'b1001110, so data_o = 21'h123C4E.
- Back-pressure: hold out_ready_i = 0 for 20 cycles after out_valid_o rises.
  - data_o and out_valid_o stay constant throughout.
  - in_ready_o stays 0 throughout.
  - A new in_valid_i pulse during the stall is ignored.
  - Releasing out_ready_i completes the transfer and in_ready_o returns to 1 the next cycle.
- Reset mid-block: assert reset_n_i = 0 at step k = 3 -> outputs return to reset values immediately. A new block accepted after release encodes correctly, with no residual trellis state.
- Back-to-back: 50 random blocks with out_ready_i = 1 and in_valid_i always 1 -> each data_o matches a reference model and blocks are accepted every 9 cycles.
